// File: rtl/clock_display_core_if.sv
// User controls in, multiplexed display pins out, for the HH:MM[:SS] clock core.
interface clock_display_core_if #(
  parameter int NUM_DIGITS = 6
);
  logic                  ena;
  logic                  btn_mode;
  logic                  btn_adj;
  logic                  fmt_12h;
  logic [6:0]            seg_out;
  logic [NUM_DIGITS-1:0] dig_en;
  logic                  pm;
  logic                  sec_pulse;
  logic [1:0]            mode_o;

  modport master (
    input  ena, btn_mode, btn_adj, fmt_12h,
    output seg_out, dig_en, pm, sec_pulse, mode_o
  );

  modport slave (
    output ena, btn_mode, btn_adj, fmt_12h,
    input  seg_out, dig_en, pm, sec_pulse, mode_o
  );
endinterface

// File: rtl/clock_display_core.sv
// Single-clock HH:MM[:SS] timekeeper: button debounce, set-mode FSM,
// 12/24h decode and a registered multiplexed 7-segment scan.
module clock_display_core #(
  parameter int SEC_DIV        = 10_000_000,
  parameter int SCAN_DIV       = 5_000,
  parameter int NUM_DIGITS     = 6,
  parameter int DEBOUNCE_CYC   = 20_000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clock_display_core_if.master bus
);
  localparam int PW = $clog2(SEC_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int IW = 3;
  localparam int FIELD_BASE = (NUM_DIGITS == 4) ? 1 : 0;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [6:0] SEG_MASK = {7{SEG_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_SEC = 2'd1,
    SET_MIN = 2'd2,
    SET_HR  = 2'd3
  } mode_t;

  // ---------------- buttons: sync, debounce, rising-edge press ----------
  logic [1:0] btn_raw;
  logic [1:0] press;
  logic       mode_press;
  logic       adj_press;

  assign btn_raw    = {bus.btn_adj, bus.btn_mode};
  assign mode_press = press[0];
  assign adj_press  = press[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic [1:0]    sync_reg;
      logic [DW-1:0] cnt_reg;
      logic          level_reg;
      logic          level_d_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_reg    <= '0;
          cnt_reg     <= '0;
          level_reg   <= 1'b0;
          level_d_reg <= 1'b0;
        end else if (bus.ena) begin
          sync_reg    <= {sync_reg[0], btn_raw[gi]};
          level_d_reg <= level_reg;
          // Any return to the accepted level restarts the stability count.
          if (sync_reg[1] == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DW'(DEBOUNCE_CYC - 1)) begin
            cnt_reg   <= '0;
            level_reg <= sync_reg[1];
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = level_reg & ~level_d_reg;
    end
  endgenerate

  // ---------------- time keeping and mode FSM --------------------------
  mode_t         mode_reg;
  logic [PW-1:0] presc_reg;
  logic [3:0]    s0_reg, s1_reg, m0_reg, m1_reg;
  logic [4:0]    hr_reg;
  logic          tick;
  logic [8:0]    sec_inc;
  logic [8:0]    min_inc;
  logic [4:0]    hr_inc;

  // Returns {carry, tens, units} for a BCD 00..59 field.
  function automatic logic [8:0] inc60(input logic [3:0] tens, input logic [3:0] units);
    logic [8:0] r;
    if (units != 4'd9)     r = {1'b0, tens, units + 4'd1};
    else if (tens != 4'd5) r = {1'b0, tens + 4'd1, 4'd0};
    else                   r = {1'b1, 4'd0, 4'd0};
    return r;
  endfunction

  assign sec_inc       = inc60(s1_reg, s0_reg);
  assign min_inc       = inc60(m1_reg, m0_reg);
  assign hr_inc        = (hr_reg == 5'd23) ? 5'd0 : hr_reg + 5'd1;
  assign tick          = (mode_reg == RUN) && (presc_reg == PW'(SEC_DIV - 1));
  assign bus.sec_pulse = tick & bus.ena;
  assign bus.mode_o    = mode_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_reg  <= RUN;
      presc_reg <= '0;
      s0_reg    <= '0;
      s1_reg    <= '0;
      m0_reg    <= '0;
      m1_reg    <= '0;
      hr_reg    <= '0;
    end else if (bus.ena) begin
      if (mode_reg != RUN || mode_press || tick) presc_reg <= '0;
      else                                       presc_reg <= presc_reg + 1'b1;

      if (mode_press) begin
        case (mode_reg)
          RUN:     mode_reg <= (NUM_DIGITS == 4) ? SET_MIN : SET_SEC;
          SET_SEC: mode_reg <= SET_MIN;
          SET_MIN: mode_reg <= SET_HR;
          default: mode_reg <= RUN;
        endcase
      end

      // A tick only occurs in RUN and adjust only acts in SET_*, so they never collide.
      if (tick) begin
        {s1_reg, s0_reg} <= sec_inc[7:0];
        if (sec_inc[8]) begin
          {m1_reg, m0_reg} <= min_inc[7:0];
          if (min_inc[8]) hr_reg <= hr_inc;
        end
      end else if (adj_press && !mode_press) begin
        case (mode_reg)
          SET_SEC: {s1_reg, s0_reg} <= sec_inc[7:0];
          SET_MIN: {m1_reg, m0_reg} <= min_inc[7:0];
          SET_HR:  hr_reg <= hr_inc;
          default: ;
        endcase
      end
    end
  end

  // ---------------- hour decode ----------------------------------------
  logic [4:0] hr_disp;
  logic [3:0] hd, hu;
  logic       pm_next;

  always_comb begin
    hr_disp = hr_reg;
    pm_next = 1'b0;
    if (bus.fmt_12h) begin
      pm_next = (hr_reg >= 5'd12);
      if (hr_reg == 5'd0)       hr_disp = 5'd12;
      else if (hr_reg > 5'd12)  hr_disp = hr_reg - 5'd12;
    end
    // Low-nibble subtraction is exact modulo 16 for these ranges.
    if (hr_disp >= 5'd20) begin
      hd = 4'd2;
      hu = hr_disp[3:0] - 4'd4;
    end else if (hr_disp >= 5'd10) begin
      hd = 4'd1;
      hu = hr_disp[3:0] - 4'd10;
    end else begin
      hd = 4'd0;
      hu = hr_disp[3:0];
    end
  end

  // ---------------- digit selection ------------------------------------
  logic [3:0] all_digits [6];
  logic [3:0] digit_val  [NUM_DIGITS];

  always_comb begin
    all_digits[0] = s0_reg;
    all_digits[1] = s1_reg;
    all_digits[2] = m0_reg;
    all_digits[3] = m1_reg;
    all_digits[4] = hu;
    all_digits[5] = hd;
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      localparam int    J          = gi + 2 * FIELD_BASE;
      localparam mode_t FIELD_MODE = mode_t'(2'(J / 2 + 1));
      assign digit_val[gi] = (mode_reg == RUN || mode_reg == FIELD_MODE) ? all_digits[J] : BLANK_CODE;
    end
  endgenerate

  // ---------------- scan and registered outputs ------------------------
  logic [SW-1:0]         scan_cnt_reg;
  logic [IW-1:0]         idx_reg;
  logic [3:0]            cur_digit;
  logic [6:0]            seg_reg;
  logic [NUM_DIGITS-1:0] dig_en_reg;
  logic                  pm_reg;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  always_comb begin
    cur_digit = BLANK_CODE;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == IW'(i)) cur_digit = digit_val[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_reg <= '0;
      idx_reg      <= '0;
      seg_reg      <= SEG_MASK;
      dig_en_reg   <= NUM_DIGITS'(1);
      pm_reg       <= 1'b0;
    end else if (bus.ena) begin
      if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
        scan_cnt_reg <= '0;
        idx_reg      <= (idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + 1'b1;
      end
      dig_en_reg <= NUM_DIGITS'(1) << idx_reg;
      seg_reg    <= seg_encode(cur_digit) ^ SEG_MASK;
      pm_reg     <= pm_next;
    end
  end

  assign bus.seg_out = seg_reg;
  assign bus.dig_en  = dig_en_reg;
  assign bus.pm      = pm_reg;
endmodule

// File: tb/tb_clock_display_core.sv
// Directed bench for clock_display_core: a 6-digit active-high instance and a
// 4-digit active-low instance, fast dividers, hand-computed expectations.
module tb_clock_display_core;
  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  localparam logic [6:0] SG0 = 7'h3F, SG1 = 7'h06, SG2 = 7'h5B, SG3 = 7'h4F;
  localparam logic [6:0] SG5 = 7'h6D, SG8 = 7'h7F, SG9 = 7'h6F, SGB = 7'h00;

  clock_display_core_if #(.NUM_DIGITS(6)) bus6 ();
  clock_display_core_if #(.NUM_DIGITS(4)) bus4 ();

  clock_display_core #(
    .SEC_DIV(10), .SCAN_DIV(4), .NUM_DIGITS(6), .DEBOUNCE_CYC(2), .SEG_ACTIVE_LOW(1'b0)
  ) dut6 (
    .clk(clk), .rst_n(rst_n), .bus(bus6)
  );

  clock_display_core #(
    .SEC_DIV(10), .SCAN_DIV(4), .NUM_DIGITS(4), .DEBOUNCE_CYC(2), .SEG_ACTIVE_LOW(1'b1)
  ) dut4 (
    .clk(clk), .rst_n(rst4_n), .bus(bus4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic press6(input logic m, input logic a);
    @(negedge clk);
    bus6.btn_mode = m;
    bus6.btn_adj  = a;
    repeat (6) @(negedge clk);
    bus6.btn_mode = 1'b0;
    bus6.btn_adj  = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic press4_mode();
    @(negedge clk);
    bus4.btn_mode = 1'b1;
    repeat (6) @(negedge clk);
    bus4.btn_mode = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic adj6(input int n);
    for (int i = 0; i < n; i++) press6(1'b0, 1'b1);
  endtask

  // Waits (bounded) for the given digit to be enabled and checks its segments.
  task automatic expect_digit(input string tag, input bit use4, input int idx, input logic [6:0] exp);
    logic [6:0] seg;
    logic [5:0] want;
    bit         ok;
    want = 6'd1 << idx;
    ok   = 1'b0;
    seg  = '0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (use4) begin
        if ({2'b00, bus4.dig_en} == want) begin ok = 1'b1; seg = bus4.seg_out; end
      end else begin
        if (bus6.dig_en == want) begin ok = 1'b1; seg = bus6.seg_out; end
      end
    end
    if (ok) check(tag, seg, exp);
    else    check({tag, "_timeout"}, ok, 1);
  endtask

  task automatic reset6();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   pulses;
    bit   glitch;
    bit   ok;
    logic [5:0] exp_dig;

    rst_n = 1'b0;  rst4_n = 1'b0;
    bus6.ena = 1'b1; bus6.btn_mode = 1'b0; bus6.btn_adj = 1'b0; bus6.fmt_12h = 1'b0;
    bus4.ena = 1'b1; bus4.btn_mode = 1'b0; bus4.btn_adj = 1'b0; bus4.fmt_12h = 1'b0;

    // ---- reset state and free-running scan / second tick ----
    repeat (3) @(negedge clk);
    check("rst_dig_en", bus6.dig_en, 6'b000001);
    check("rst_seg", bus6.seg_out, SGB);
    check("rst_pm", bus6.pm, 0);
    check("rst_sec_pulse", bus6.sec_pulse, 0);
    check("rst_mode", bus6.mode_o, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      exp_dig = 6'd1 << (((k - 1) / 4) % 6);
      check($sformatf("run_dig_en_k%0d", k), bus6.dig_en, exp_dig);
      check($sformatf("run_pulse_k%0d", k), bus6.sec_pulse, ((k % 10) == 9) ? 1 : 0);
      if (k == 1)  check("run_s0_init", bus6.seg_out, SG0);
      if (k == 25) check("run_s0_after2", bus6.seg_out, SG2);
    end

    // ---- SET_SEC: blanking, frozen prescaler, 60 presses wrap ----
    reset6();
    press6(1'b1, 1'b0);
    check("setsec_mode", bus6.mode_o, 1);
    expect_digit("setsec_s0", 1'b0, 0, SG0);
    for (int i = 2; i < 6; i++) expect_digit($sformatf("setsec_blank%0d", i), 1'b0, i, SGB);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus6.sec_pulse) pulses++;
    end
    check("setsec_frozen_pulses", pulses, 0);
    adj6(60);
    expect_digit("setsec_wrap_s0", 1'b0, 0, SG0);
    expect_digit("setsec_wrap_s1", 1'b0, 1, SG0);

    // ---- set 23:59:58 ----
    adj6(58);
    expect_digit("set58_s0", 1'b0, 0, SG8);
    expect_digit("set58_s1", 1'b0, 1, SG5);
    press6(1'b1, 1'b0);
    check("setmin_mode", bus6.mode_o, 2);
    expect_digit("setmin_m0_unchanged", 1'b0, 2, SG0);
    expect_digit("setmin_m1_unchanged", 1'b0, 3, SG0);
    adj6(59);
    expect_digit("set59_m0", 1'b0, 2, SG9);
    expect_digit("set59_m1", 1'b0, 3, SG5);
    expect_digit("setmin_s0_blank", 1'b0, 0, SGB);
    press6(1'b1, 1'b0);
    check("sethr_mode", bus6.mode_o, 3);

    // ---- hour decode ----
    bus6.fmt_12h = 1'b1;
    expect_digit("h0_12h_hu", 1'b0, 4, SG2);
    expect_digit("h0_12h_hd", 1'b0, 5, SG1);
    check("h0_12h_pm", bus6.pm, 0);
    adj6(13);
    expect_digit("h13_12h_hu", 1'b0, 4, SG1);
    expect_digit("h13_12h_hd", 1'b0, 5, SG0);
    check("h13_12h_pm", bus6.pm, 1);
    bus6.fmt_12h = 1'b0;
    expect_digit("h13_24h_hu", 1'b0, 4, SG3);
    expect_digit("h13_24h_hd", 1'b0, 5, SG1);
    check("h13_24h_pm", bus6.pm, 0);
    adj6(10);
    expect_digit("h23_hu", 1'b0, 4, SG3);
    expect_digit("h23_hd", 1'b0, 5, SG2);

    // ---- back to RUN, rollover 23:59:58 -> 00:00:00 ----
    press6(1'b1, 1'b0);
    check("run_mode", bus6.mode_o, 0);
    pulses = 0;
    glitch = 1'b0;
    for (int c = 0; c < 40 && pulses < 2; c++) begin
      @(negedge clk);
      if (bus6.sec_pulse) pulses++;
      if (!$onehot(bus6.dig_en)) glitch = 1'b1;
    end
    check("rollover_pulses", pulses, 2);
    repeat (2) @(negedge clk);
    expect_digit("roll_s1", 1'b0, 1, SG0);
    expect_digit("roll_m0", 1'b0, 2, SG0);
    expect_digit("roll_m1", 1'b0, 3, SG0);
    expect_digit("roll_hu", 1'b0, 4, SG0);
    expect_digit("roll_hd", 1'b0, 5, SG0);
    check("roll_dig_en_glitch", glitch, 0);

    // ---- glitch rejection, simultaneous presses, clock-enable freeze ----
    reset6();
    press6(1'b1, 1'b0);
    @(negedge clk);
    bus6.btn_mode = 1'b1;
    @(negedge clk);
    bus6.btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_mode", bus6.mode_o, 1);
    press6(1'b1, 1'b0);
    press6(1'b1, 1'b0);
    press6(1'b1, 1'b1);
    check("both_mode", bus6.mode_o, 0);
    expect_digit("both_hu", 1'b0, 4, SG0);
    expect_digit("both_hd", 1'b0, 5, SG0);

    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (bus6.dig_en != 6'b000001) ok = 1'b1;
    end
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (bus6.dig_en == 6'b000001) ok = 1'b1;
    end
    check("freeze_sync", ok, 1);
    bus6.ena = 1'b0;
    pulses = 0;
    bus6.btn_mode = 1'b1;
    repeat (20) begin @(negedge clk); if (bus6.sec_pulse) pulses++; end
    bus6.btn_mode = 1'b0;
    repeat (30) begin @(negedge clk); if (bus6.sec_pulse) pulses++; end
    check("freeze_pulses", pulses, 0);
    check("freeze_dig_en", bus6.dig_en, 6'b000001);
    check("freeze_mode", bus6.mode_o, 0);
    bus6.ena = 1'b1;
    repeat (3) @(negedge clk);
    check("resume_dig_en_hold", bus6.dig_en, 6'b000001);
    @(negedge clk);
    check("resume_dig_en_step", bus6.dig_en, 6'b000010);
    repeat (10) @(negedge clk);
    check("freeze_press_lost", bus6.mode_o, 0);

    // ---- 4-digit, active-low instance ----
    check("d4_rst_seg", bus4.seg_out, 7'h7F);
    check("d4_rst_dig_en", bus4.dig_en, 4'b0001);
    @(negedge clk);
    rst4_n = 1'b1;
    press4_mode();
    check("d4_mode", bus4.mode_o, 2);
    expect_digit("d4_m0", 1'b1, 0, 7'h40);
    expect_digit("d4_hu_blank", 1'b1, 2, 7'h7F);
    @(negedge clk);
    rst4_n = 1'b0;
    repeat (2) @(negedge clk);
    check("d4_rerst_seg", bus4.seg_out, 7'h7F);
    check("d4_rerst_dig_en", bus4.dig_en, 4'b0001);
    check("d4_rerst_mode", bus4.mode_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
